// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - registered issue/retire stage around a combinational barrel shifter
module shift_issue_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  input  logic [$clog2(WIDTH)-1:0]   req_amt,
  input  logic                       req_dir,
  input  logic [1:0]                 req_type,
  input  logic [TAG_W-1:0]           req_tag,
  output logic [WIDTH-1:0]           sh_in,
  output logic [$clog2(WIDTH)-1:0]   sh_ct,
  output logic                       sh_dir,
  output logic [1:0]                 sh_type,
  input  logic [WIDTH-1:0]           sh_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_carry,
  output logic                       rsp_zero,
  output logic                       rsp_neg
);

  localparam int AW = $clog2(WIDTH);

  // Stage register S1
  logic             v1;
  logic [WIDTH-1:0] s1_data;
  logic [AW-1:0]    s1_amt;
  logic             s1_dir;
  logic [1:0]       s1_type;
  logic [TAG_W-1:0] s1_tag;

  // Two-entry output buffer
  logic [WIDTH-1:0] f_data [2];
  logic [TAG_W-1:0] f_tag  [2];
  logic [1:0]       f_carry;
  logic [1:0]       f_zero;
  logic [1:0]       f_neg;
  logic             head;
  logic             tail;
  logic [1:0]       count;

  logic             pop;
  logic             advance;
  logic             accept;
  logic             carry;
  logic [AW-1:0]    lidx;
  logic [AW-1:0]    ridx;

  assign rsp_valid = (count != 2'd0);
  // A pop during flush is ignored because the whole buffer is discarded anyway.
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign advance   = v1 && ((count != 2'd2) || pop);
  // rst gates ready so nothing is offered while the stage is held in reset.
  assign req_ready = !rst && !flush && (!v1 || advance);
  assign accept    = req_valid && req_ready;

  assign sh_in   = s1_data;
  assign sh_ct   = s1_amt;
  assign sh_dir  = s1_dir;
  assign sh_type = s1_type;

  assign rsp_data  = f_data[head];
  assign rsp_tag   = f_tag[head];
  assign rsp_carry = f_carry[head];
  assign rsp_zero  = f_zero[head];
  assign rsp_neg   = f_neg[head];

  // WIDTH-n wraps naturally in AW bits; only used when n != 0.
  assign lidx = {AW{1'b0}} - s1_amt;
  assign ridx = s1_amt - {{(AW-1){1'b0}}, 1'b1};

  // Carry-out: last bit shifted or rotated out of the operand
  always_comb begin
    carry = 1'b0;
    if (s1_amt != '0 && s1_type != 2'd0) begin
      if (s1_type == 2'd3)
        carry = s1_dir ? sh_out[0] : sh_out[WIDTH-1];
      else
        carry = s1_dir ? s1_data[lidx] : s1_data[ridx];
    end
  end

  // S1: load on acceptance, empty when its operation moves into the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_amt  <= '0;
      s1_dir  <= 1'b0;
      s1_type <= 2'd0;
      s1_tag  <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (accept) begin
      v1      <= 1'b1;
      s1_data <= req_data;
      s1_amt  <= req_amt;
      s1_dir  <= req_dir;
      s1_type <= req_type;
      s1_tag  <= req_tag;
    end else if (advance) begin
      v1 <= 1'b0;
    end
  end

  // Output buffer: push shifter result on advance, pop on downstream handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_tag[i]  <= '0;
      end
      f_carry <= '0;
      f_zero  <= '0;
      f_neg   <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (advance) begin
        f_data[tail]  <= sh_out;
        f_tag[tail]   <= s1_tag;
        f_carry[tail] <= carry;
        f_zero[tail]  <= (sh_out == '0);
        f_neg[tail]   <= sh_out[WIDTH-1];
        tail          <= ~tail;
      end
      if (pop)
        head <= ~head;
      case ({advance, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - randomized and directed checks of shift_issue_stage against a queue model
module tb_shift_issue_stage;

  localparam int W  = 64;
  localparam int TW = 4;
  localparam int AW = 6;

  logic          clk, rst, flush;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_data;
  logic [AW-1:0] req_amt;
  logic          req_dir;
  logic [1:0]    req_type;
  logic [TW-1:0] req_tag;
  logic [W-1:0]  sh_in, sh_out;
  logic [AW-1:0] sh_ct;
  logic          sh_dir;
  logic [1:0]    sh_type;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_carry, rsp_zero, rsp_neg;

  int n_vec = 0;
  int n_err = 0;

  shift_issue_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_dir(req_dir), .req_type(req_type), .req_tag(req_tag),
    .sh_in(sh_in), .sh_ct(sh_ct), .sh_dir(sh_dir), .sh_type(sh_type), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input logic [AW-1:0] n,
                                             input logic dir, input logic [1:0] typ);
    int k;
    logic [W-1:0] r;
    k = int'(n);
    case (typ)
      2'd1:    r = dir ? (x << k) : (x >> k);
      2'd2:    r = dir ? (x << k) : W'($signed(x) >>> k);
      2'd3:    r = (k == 0) ? x : (dir ? ((x << k) | (x >> (W - k))) : ((x >> k) | (x << (W - k))));
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] x, input logic [AW-1:0] n,
                                     input logic dir, input logic [1:0] typ, input logic [W-1:0] res);
    logic [W:0] wide;
    if (n == '0 || typ == 2'd0) return 1'b0;
    if (typ == 2'd3) return dir ? res[0] : res[W-1];
    if (dir) begin
      wide = {1'b0, x} << int'(n);
      return wide[W];
    end
    wide = {x, 1'b0} >> int'(n);
    return wide[0];
  endfunction

  // Combinational shifter seen by the DUT
  always_comb sh_out = ref_shift(sh_in, sh_ct, sh_dir, sh_type);

  typedef struct {
    logic [W-1:0]  x;
    logic [AW-1:0] n;
    logic          dir;
    logic [1:0]    typ;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          carry;
  } item_t;

  item_t q[$];
  int    m_cnt = 0;
  bit    m_v1  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model compare and update, once per cycle at the falling edge
  initial begin
    item_t it;
    bit pop, adv, acc, er;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_flags", W'({rsp_tag, rsp_carry, rsp_zero, rsp_neg}), '0);
        chk("rst_sh", sh_in | W'({sh_ct, sh_dir, sh_type}), '0);
        q.delete();
        m_cnt = 0;
        m_v1  = 0;
      end else begin
        er = !flush && (!m_v1 || m_cnt < 2 || (m_cnt > 0 && rsp_ready));
        chk("req_ready", W'(req_ready), W'(er));
        chk("rsp_valid", W'(rsp_valid), W'(m_cnt > 0));
        if (m_cnt > 0) begin
          chk("rsp_data", rsp_data, q[0].res);
          chk("rsp_tag", W'(rsp_tag), W'(q[0].tag));
          chk("rsp_carry", W'(rsp_carry), W'(q[0].carry));
          chk("rsp_zero", W'(rsp_zero), W'(q[0].res == '0));
          chk("rsp_neg", W'(rsp_neg), W'(q[0].res[W-1]));
        end
        if (m_v1) begin
          chk("sh_in", sh_in, q[q.size()-1].x);
          chk("sh_ctl", W'({sh_ct, sh_dir, sh_type}),
              W'({q[q.size()-1].n, q[q.size()-1].dir, q[q.size()-1].typ}));
        end
        if (flush) begin
          q.delete();
          m_cnt = 0;
          m_v1  = 0;
        end else begin
          pop = (m_cnt > 0) && rsp_ready;
          adv = m_v1 && (m_cnt < 2 || pop);
          acc = req_valid && er;
          if (pop) it = q.pop_front();
          m_cnt = m_cnt + (adv ? 1 : 0) - (pop ? 1 : 0);
          if (acc) begin
            it.x     = req_data;
            it.n     = req_amt;
            it.dir   = req_dir;
            it.typ   = req_type;
            it.tag   = req_tag;
            it.res   = ref_shift(req_data, req_amt, req_dir, req_type);
            it.carry = ref_carry(req_data, req_amt, req_dir, req_type, it.res);
            q.push_back(it);
            m_v1 = 1;
          end else if (adv) begin
            m_v1 = 0;
          end
        end
      end
    end
  end

  task automatic drain();
    req_valid = 0;
    flush     = 0;
    rsp_ready = 1;
    repeat (5) tick();
  endtask

  task automatic set_req(input logic [W-1:0] x, input logic [AW-1:0] n, input logic dir,
                         input logic [1:0] typ, input logic [TW-1:0] tag);
    req_valid = 1;
    req_data  = x;
    req_amt   = n;
    req_dir   = dir;
    req_type  = typ;
    req_tag   = tag;
  endtask

  // One request into an empty stage, literal expectations, one-cycle latency
  task automatic single(input string nm, input logic [W-1:0] x, input logic [AW-1:0] n,
                        input logic dir, input logic [1:0] typ, input logic [W-1:0] ed,
                        input logic ec, input logic ez, input logic en);
    rsp_ready = 1;
    set_req(x, n, dir, typ, 4'hA);
    @(negedge clk);
    chk({nm, "_ready"}, W'(req_ready), W'(1));
    tick();
    req_valid = 0;
    @(negedge clk);
    chk({nm, "_early"}, W'(rsp_valid), W'(0));
    @(negedge clk);
    chk({nm, "_valid"}, W'(rsp_valid), W'(1));
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_flags"}, W'({rsp_tag, rsp_carry, rsp_zero, rsp_neg}), W'({4'hA, ec, ez, en}));
    tick();
  endtask

  initial begin
    rst = 1; flush = 0; req_valid = 0; rsp_ready = 0;
    req_data = '0; req_amt = '0; req_dir = 0; req_type = 0; req_tag = '0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", W'(req_ready), W'(1));
    tick();

    single("lsl", 64'h8000_0000_0000_0001, 6'd1, 1'b1, 2'd1, 64'h2, 1'b1, 1'b0, 1'b0);
    single("asr", 64'h8000_0000_0000_0000, 6'd4, 1'b0, 2'd2, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    single("ror", 64'h1, 6'd1, 1'b0, 2'd3, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    single("none", 64'h1234, 6'd7, 1'b1, 2'd0, 64'h1234, 1'b0, 1'b0, 1'b0);
    single("lsl0", 64'h1, 6'd0, 1'b1, 2'd1, 64'h1, 1'b0, 1'b0, 1'b0);
    single("lsr", 64'h1, 6'd1, 1'b0, 2'd1, 64'h0, 1'b1, 1'b1, 1'b0);

    // Backpressure: three fit, the fourth waits until the first pop
    drain();
    rsp_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      set_req(64'($urandom) << 20, 6'($urandom), 1'($urandom), 2'($urandom), 4'(i));
      @(negedge clk);
      chk("bp_accept", W'(req_ready), W'(1));
      tick();
    end
    req_tag = 4'd4;
    @(negedge clk);
    chk("bp_full", W'(req_ready), W'(0));
    tick();
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_reopen", W'(req_ready), W'(1));
    chk("bp_tag1", W'(rsp_tag), W'(1));
    tick();
    req_valid = 0;
    for (int t = 2; t <= 4; t++) begin
      @(negedge clk);
      chk("bp_order", W'({rsp_valid, rsp_tag}), W'({1'b1, 4'(t)}));
      tick();
    end
    @(negedge clk);
    chk("bp_empty", W'(rsp_valid), W'(0));

    // Flush with three in flight
    drain();
    rsp_ready = 0;
    for (int i = 5; i <= 7; i++) begin
      set_req(64'($urandom), 6'($urandom), 1'($urandom), 2'($urandom), 4'(i));
      tick();
    end
    flush = 1;
    req_tag = 4'd8;
    @(negedge clk);
    chk("fl_ready_low", W'(req_ready), W'(0));
    tick();
    flush = 0;
    req_valid = 0;
    @(negedge clk);
    chk("fl_empty", W'({rsp_valid, req_ready}), W'(2'b01));
    tick();
    rsp_ready = 1;
    set_req(64'h0F, 6'd4, 1'b1, 2'd1, 4'd9);
    tick();
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_tag9", W'({rsp_valid, rsp_tag, rsp_data[7:0]}), W'({1'b1, 4'd9, 8'hF0}));
    tick();
    @(negedge clk);
    chk("fl_alone", W'(rsp_valid), W'(0));

    // Asynchronous reset with two in flight
    drain();
    rsp_ready = 0;
    set_req(64'h55, 6'd1, 1'b1, 2'd1, 4'd10);
    tick();
    req_tag = 4'd11;
    tick();
    req_valid = 0;
    rst = 1;
    #1;
    chk("ar_now", W'({req_ready, rsp_valid, rsp_tag}), '0);
    chk("ar_data", rsp_data | sh_in, '0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("ar_nostale", W'({rsp_valid, req_ready}), W'(2'b01));
    tick();
    single("ar_rol", 64'h8000_0000_0000_0001, 6'd1, 1'b1, 2'd3, 64'h3, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(3) != 0);
      req_data  = {$urandom, $urandom};
      if ($urandom_range(7) == 0) req_data[W-1] = 1'b1;
      req_amt   = ($urandom_range(9) == 0) ? 6'd0 : 6'($urandom);
      req_dir   = 1'($urandom);
      req_type  = 2'($urandom);
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(49) == 0);
      rst       = ($urandom_range(199) == 0);
      tick();
    end
    rst = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
